// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// FSM state type and counter width.
package hazard_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMEM = 2'b11;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        LSTALL = 2'b01,
        FLUSH  = 2'b10
    } state_e;

    // Operand select for one source register; an E-stage ALU result beats M.
    function automatic logic [1:0] fwd_sel(
        input logic             use_src,
        input logic [REG_W-1:0] src,
        input logic             ewreg,
        input logic             em2reg,
        input logic [REG_W-1:0] egpr,
        input logic             mwreg,
        input logic             mm2reg,
        input logic [REG_W-1:0] mgpr
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && (src != '0)) begin
            if (ewreg && !em2reg && (egpr == src)) begin
                sel = FWD_EALU;
            end else if (mwreg && (mgpr == src)) begin
                sel = mm2reg ? FWD_MMEM : FWD_MALU;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {Width{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// a small tracking FSM with a sticky protocol-error flag, and event counters.
module hazard_ctl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] drs,
    input  logic [REG_W-1:0] drt,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic             dbranch_taken,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [REG_W-1:0] eGPR_org,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [REG_W-1:0] mGPR,
    input  logic             clr_cnt,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall,
    output logic             flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e state_q;
    logic   err_q;
    logic   lu;
    logic   lu_rs;
    logic   lu_rt;

    always_comb begin
        fwda = fwd_sel(duse_rs, drs, ewreg, em2reg, eGPR_org, mwreg, mm2reg, mGPR);
        fwdb = fwd_sel(duse_rt, drt, ewreg, em2reg, eGPR_org, mwreg, mm2reg, mGPR);
    end

    // A load in E cannot be forwarded; any consumer of its destination must wait.
    always_comb begin
        lu_rs = duse_rs && (eGPR_org == drs);
        lu_rt = duse_rt && (eGPR_org == drt);
        lu    = ewreg && em2reg && (eGPR_org != '0) && (lu_rs || lu_rt);
        stall = lu;
        flush = dbranch_taken && !lu;
    end

    // A load-use stall lasts exactly one cycle, so LU seen again in LSTALL is an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            if (lu && (state_q == LSTALL)) begin
                err_q <= 1'b1;
            end
            if (lu) begin
                state_q <= LSTALL;
            end else if (flush) begin
                state_q <= FLUSH;
            end else begin
                state_q <= RUN;
            end
        end
    end

    assign err = err_q;

    sat_counter #(
        .Width(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall),
        .clr  (clr_cnt),
        .count(stall_cnt)
    );

    sat_counter #(
        .Width(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush),
        .clr  (clr_cnt),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed cases, random traffic and
// counter saturation, all against a behavioural model kept here.
module tb_hazard_ctl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  drs, drt, eGPR_org, mGPR;
    logic        duse_rs, duse_rt, dbranch_taken;
    logic        ewreg, em2reg, mwreg, mm2reg, clr_cnt;
    logic [1:0]  fwda, fwdb;
    logic        stall, flush, err;
    logic [15:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    // Model state
    int m_stall_cnt, m_flush_cnt;
    bit m_err, m_prev_lu, m_prev_flush;
    bit m_lu, m_flush;

    always #5 clk = ~clk;

    hazard_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .drs          (drs),
        .drt          (drt),
        .duse_rs      (duse_rs),
        .duse_rt      (duse_rt),
        .dbranch_taken(dbranch_taken),
        .ewreg        (ewreg),
        .em2reg       (em2reg),
        .eGPR_org     (eGPR_org),
        .mwreg        (mwreg),
        .mm2reg       (mm2reg),
        .mGPR         (mGPR),
        .clr_cnt      (clr_cnt),
        .fwda         (fwda),
        .fwdb         (fwdb),
        .stall        (stall),
        .flush        (flush),
        .err          (err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Which value must feed an operand: 0 regfile, 1 E ALU, 2 M ALU, 3 M memory.
    function automatic int exp_fwd(input bit use_src, input int src);
        if (!use_src || src == 0) return 0;
        if (ewreg && !em2reg && int'(eGPR_org) == src) return 1;
        if (mwreg && int'(mGPR) == src) return mm2reg ? 3 : 2;
        return 0;
    endfunction

    function automatic bit exp_lu();
        bit hit;
        hit = (duse_rs && eGPR_org == drs) || (duse_rt && eGPR_org == drt);
        return ewreg && em2reg && eGPR_org != 0 && hit;
    endfunction

    function automatic int exp_state();
        if (m_prev_lu) return int'(LSTALL);
        if (m_prev_flush) return int'(FLUSH);
        return int'(RUN);
    endfunction

    task automatic model_reset();
        m_stall_cnt = 0; m_flush_cnt = 0; m_err = 0;
        m_prev_lu = 0; m_prev_flush = 0;
    endtask

    task automatic idle_inputs();
        drs = 0; drt = 0; duse_rs = 0; duse_rt = 0; dbranch_taken = 0;
        ewreg = 0; em2reg = 0; eGPR_org = 0; mwreg = 0; mm2reg = 0; mGPR = 0;
        clr_cnt = 0;
    endtask

    task automatic check_regs();
        chk("state", int'(dut.state_q), exp_state());
        chk("err", int'(err), int'(m_err));
        chk("stall_cnt", int'(stall_cnt), m_stall_cnt);
        chk("flush_cnt", int'(flush_cnt), m_flush_cnt);
    endtask

    // One cycle: check combinational outputs mid-cycle, clock, then check registered state.
    task automatic step();
        #1;
        m_lu = exp_lu();
        m_flush = dbranch_taken && !m_lu;
        chk("fwda", int'(fwda), exp_fwd(duse_rs, int'(drs)));
        chk("fwdb", int'(fwdb), exp_fwd(duse_rt, int'(drt)));
        chk("stall", int'(stall), int'(m_lu));
        chk("flush", int'(flush), int'(m_flush));
        @(posedge clk);
        if (m_lu && m_prev_lu) m_err = 1;
        if (clr_cnt) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (m_lu && m_stall_cnt < 65535) m_stall_cnt++;
            if (m_flush && m_flush_cnt < 65535) m_flush_cnt++;
        end
        m_prev_lu = m_lu;
        m_prev_flush = m_flush;
        #1;
        check_regs();
    endtask

    task automatic quick_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        quick_step();
        quick_step();
        chk("rst_state", int'(dut.state_q), int'(RUN));
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        chk("rst_flush_cnt", int'(flush_cnt), 0);
        chk("rst_err", int'(err), 0);
        // Combinational outputs still track inputs while in reset.
        ewreg = 1; eGPR_org = 5; drs = 5; duse_rs = 1;
        #1;
        chk("rst_comb_fwda", int'(fwda), 1);
        rst = 0;
        idle_inputs();
        #2;

        // E ALU forward, no stall
        ewreg = 1; em2reg = 0; eGPR_org = 5; drs = 5; duse_rs = 1;
        #1;
        chk("ealu_fwda", int'(fwda), 1);
        chk("ealu_stall", int'(stall), 0);
        step();

        // Load-use on rt together with a taken branch: stall wins
        idle_inputs();
        ewreg = 1; em2reg = 1; eGPR_org = 7; drt = 7; duse_rt = 1; dbranch_taken = 1;
        #1;
        chk("lu_stall", int'(stall), 1);
        chk("lu_flush", int'(flush), 0);
        step();
        chk("lu_state", int'(dut.state_q), int'(LSTALL));
        chk("lu_stall_cnt", int'(stall_cnt), 1);

        // E and M both target r9: E wins; without E, M memory data
        idle_inputs();
        ewreg = 1; eGPR_org = 9; mwreg = 1; mm2reg = 1; mGPR = 9; drs = 9; duse_rs = 1;
        #1;
        chk("prio_fwda_e", int'(fwda), 1);
        ewreg = 0;
        #1;
        chk("prio_fwda_m", int'(fwda), 3);
        step();

        // r0 never forwards or stalls
        idle_inputs();
        ewreg = 1; em2reg = 1; eGPR_org = 0; drs = 0; duse_rs = 1;
        #1;
        chk("r0_stall", int'(stall), 0);
        chk("r0_fwda", int'(fwda), 0);
        step();

        // LU on two consecutive cycles -> sticky err
        idle_inputs();
        ewreg = 1; em2reg = 1; eGPR_org = 3; drs = 3; duse_rs = 1;
        step();
        step();
        chk("err_set", int'(err), 1);
        idle_inputs();
        step();
        chk("err_sticky", int'(err), 1);

        // Async reset mid-stall clears state and err immediately
        ewreg = 1; em2reg = 1; eGPR_org = 4; drt = 4; duse_rt = 1;
        step();
        #2;
        rst = 1;
        #1;
        chk("arst_state", int'(dut.state_q), int'(RUN));
        chk("arst_err", int'(err), 0);
        chk("arst_stall_cnt", int'(stall_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        idle_inputs();

        // Randomized traffic over a small register range to provoke matches
        for (int i = 0; i < 4000; i++) begin
            drs = 5'($urandom_range(0, 3));
            drt = 5'($urandom_range(0, 3));
            eGPR_org = 5'($urandom_range(0, 3));
            mGPR = 5'($urandom_range(0, 3));
            duse_rs = 1'($urandom);
            duse_rt = 1'($urandom);
            ewreg = 1'($urandom);
            em2reg = ($urandom_range(0, 3) == 0);
            mwreg = 1'($urandom);
            mm2reg = 1'($urandom);
            dbranch_taken = ($urandom_range(0, 3) == 0);
            clr_cnt = ($urandom_range(0, 31) == 0);
            step();
        end

        // Flush held long enough to saturate, then clear, then async reset mid-count
        rst = 1;
        #1;
        model_reset();
        rst = 0;
        idle_inputs();
        dbranch_taken = 1;
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        chk("flush_sat", int'(flush_cnt), 16'hffff);
        clr_cnt = 1;
        step();
        chk("flush_clr", int'(flush_cnt), 0);
        clr_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
        end
        chk("flush_recount", int'(flush_cnt), 50);
        #2;
        rst = 1;
        #1;
        chk("mid_rst_flush_cnt", int'(flush_cnt), 0);
        chk("mid_rst_stall_cnt", int'(stall_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        step();
        chk("post_rst_flush_cnt", int'(flush_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
